otter_fetch_stage: RTL and testbench
====================================

# otter_fetch_stage

Instruction-fetch (IF) stage of the 5-stage OTTER pipeline. It sits directly upstream of the OTTER memory's instruction port. It owns the program counter and drives the word address and read enable of that port. Because the port reads synchronously (one cycle), the block keeps its PC register aligned with the instruction word the port presents, and hands {PC, instruction, valid, error} to the IF/ID boundary. It also handles stalls, branch/jump redirects, boot and fetch-address faults.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- NOP_INSTR, 32'h0000_0013, instruction substituted whenever the output is not valid (addi x0,x0,0).
- CLK  in  1  pipeline clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- STALL  in  1  hold request from the hazard unit; freezes PC and instruction output.
- BR_TAKEN  in  1  redirect request from EX (taken branch, jal, jalr).
- BR_TARGET  in  32  redirect byte address; sampled only when BR_TAKEN=1.
- MEM_DOUT1  in  32  instruction word from the memory port, valid the cycle after the address.
- MEM_RDEN1  out  1  instruction read enable to the memory.
- MEM_ADDR1  out  14  instruction word address, equal to pc_next[15:2].
- IF_PC  out  32  byte address of the instruction on IF_INSTR.
- IF_INSTR  out  32  instruction to ID. Equals MEM_DOUT1 when IF_VALID=1, else NOP_INSTR.
- IF_VALID  out  1  IF_INSTR is a real, in-range, aligned instruction.
- IF_ERR  out  1  IF_PC is misaligned (IF_PC[1:0]≠0) or outside instruction memory (IF_PC[31:16]≠0).
- IF_CNT  out  32  count of instructions accepted by ID; wraps modulo 2^32.

## Operation
- **State registers:**
  - pc (32 bits)
  - boot (1 bit; set by reset, cleared on the first non-reset edge)
  - cnt (32 bits)
- **pc_next priority** (highest first):
  - RST → RESET_PC
  - BR_TAKEN → BR_TARGET
  - STALL or boot → pc
  - otherwise → pc + 4, 32-bit wrap (0xFFFF_FFFC + 4 = 0).
- **Combinational outputs:**
  - MEM_ADDR1 = pc_next[15:2].
  - MEM_RDEN1 = RST | BR_TAKEN | ~STALL. When it is low the memory holds MEM_DOUT1, so the instruction is frozen exactly with pc.
- **On every edge:** pc <= pc_next. boot <= RST.
- **Output decode:**
  - IF_PC = pc.
  - IF_ERR = (pc[1:0]≠0) | (pc[31:16]≠0).
  - IF_VALID = ~boot & ~IF_ERR.
  - IF_INSTR = IF_VALID ? MEM_DOUT1 : NOP_INSTR.
- **Boot bubble:** the first cycle after RST deasserts has boot=1 and outputs NOP. The PC holds at RESET_PC, and the next cycle delivers mem[RESET_PC] valid.
- **Accept:** accept = IF_VALID & ~STALL & ~BR_TAKEN. cnt increments on accept; IF_CNT = cnt.
- **Redirect wins over stall.** An instruction present during BR_TAKEN is wrong-path. It is not counted; squashing it in ID is the hazard unit's job.
- **Errored PCs:**
  - Sequential fetch continues from an errored PC, so errors persist until a redirect or reset.
  - IF_ERR does not stall fetch by itself.
  - Out-of-range addresses still drive MEM_ADDR1 with bits [15:2]; that data is never exposed as valid.
- **No instruction at the boundary is lost or duplicated** across stall, redirect or reset.

## Timing
- **Reset values**, after the first edge with RST=1:
  - IF_PC=RESET_PC, IF_VALID=0, IF_ERR=0, IF_INSTR=NOP_INSTR, IF_CNT=0.
  - MEM_RDEN1=1 and MEM_ADDR1=RESET_PC[15:2] while RST is high.
- **Fetch latency:** an address presented in cycle N appears on IF_INSTR in cycle N+1, aligned with IF_PC.
- **Throughput:** one instruction per cycle when STALL=0.
- **Redirect latency:** target visible on IF_PC and IF_INSTR in the cycle after BR_TAKEN, with no bubble.
- **STALL:** outputs are bit-identical for every cycle STALL is held, and cnt is frozen.
- **Simultaneous inputs:**
  - RST overrides BR_TAKEN and STALL.
  - BR_TAKEN overrides STALL.
  - RST mid-stall or mid-redirect gives the plain reset values.

## Test plan
1. **Boot.** Setup: RESET_PC=0, mem[0]=0x00500093, mem[1]=0x00A00113, RST held 2 cycles. Required response, cycle by cycle:
   - During reset and the first post-reset cycle: IF_VALID=0, IF_PC=0, IF_INSTR=0x00000013.
   - Next cycle: IF_PC=0, IF_INSTR=0x00500093, IF_VALID=1.
   - Following cycle: IF_PC=4, IF_INSTR=0x00A00113, IF_CNT=1.
2. **Stall.** STALL=1 for 3 cycles while IF_PC=0x8. Required response:
   - IF_PC=0x8 and IF_INSTR stay constant, MEM_RDEN1=0, IF_CNT frozen.
   - On release, the next cycle shows IF_PC=0xC with mem[3].
3. **Redirect during stall.** BR_TAKEN=1, BR_TARGET=0x40 and STALL=1 in the same cycle. Required response: the next cycle has IF_PC=0x40, IF_INSTR=mem[16] and IF_VALID=1, and IF_CNT does not increment for the redirect cycle.
4. **Fault.**
   - BR_TARGET=0x42: IF_ERR=1, IF_VALID=0, IF_INSTR=0x00000013. The following PC is 0x46, still erroring.
   - BR_TARGET=0x10000: IF_ERR=1.
5. **Wrap.** BR_TARGET=0xFFFFFFFC. Required response: IF_ERR=1, then IF_PC=0x0 with IF_VALID=1 and IF_INSTR=mem[0].
6. **Reset priority.** RST=1 together with BR_TAKEN=1 (target 0x80) and STALL=1. Required response: IF_PC=RESET_PC, IF_CNT=0, then the normal boot bubble.

Source files
------------

// File: rtl/otter_fetch_stage.sv
// OTTER instruction-fetch stage: owns the PC, drives the synchronous instruction port and
// presents a PC-aligned {pc, instr, valid, err} bundle plus an accepted-instruction count to ID.
module otter_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stall,
   input  logic        i_br_taken,
   input  logic [31:0] i_br_target,
   input  logic [31:0] i_mem_dout1,
   output logic        o_mem_rden1,
   output logic [13:0] o_mem_addr1,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_instr,
   output logic        o_if_valid,
   output logic        o_if_err,
   output logic [31:0] o_if_cnt
);

   logic [31:0] r_pc;
   logic        r_boot;
   logic        r_err;
   logic [31:0] r_cnt;

   logic [31:0] w_pc_next;
   logic        w_err_next;
   logic        w_accept;

   // Redirect outranks stall; boot holds the PC so the first real word lines up with RESET_PC.
   always_comb begin
      w_pc_next = r_pc + 32'd4;
      if (i_rst) begin
         w_pc_next = RESET_PC;
      end else if (i_br_taken) begin
         w_pc_next = i_br_target;
      end else if (i_stall || r_boot) begin
         w_pc_next = r_pc;
      end
   end

   // Fault flag is precomputed from pc_next so it lands in the same cycle as the new PC.
   assign w_err_next = (w_pc_next[1:0] != 2'b00) || (w_pc_next[31:16] != 16'h0000);

   // Holding the read enable low freezes the memory output together with the PC.
   assign o_mem_rden1 = i_rst | i_br_taken | ~i_stall;
   assign o_mem_addr1 = w_pc_next[15:2];

   assign o_if_pc    = r_pc;
   assign o_if_err   = r_err;
   assign o_if_valid = ~r_boot & ~r_err;
   assign o_if_instr = o_if_valid ? i_mem_dout1 : NOP_INSTR;
   assign o_if_cnt   = r_cnt;

   // A word shown during a redirect is wrong-path and is never counted.
   assign w_accept = o_if_valid & ~i_stall & ~i_br_taken;

   always_ff @(posedge i_clk) begin
      r_pc   <= w_pc_next;
      r_err  <= w_err_next;
      r_boot <= i_rst;
      if (i_rst) begin
         r_cnt <= 32'd0;
      end else if (w_accept) begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Directed bench for otter_fetch_stage with a synchronous instruction-memory model and a
// queue of expected post-edge outputs pushed as each step's stimulus is driven.
module tb_otter_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic        valid;
      logic        err;
      logic [31:0] cnt;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] mem_dout1;
   logic        mem_rden1;
   logic [13:0] mem_addr1;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        if_err;
   logic [31:0] if_cnt;

   logic [31:0] mem [16384];
   exp_t        sb_q[$];
   int          n_total;
   int          n_pass;

   otter_fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_stall     (stall),
      .i_br_taken  (br_taken),
      .i_br_target (br_target),
      .i_mem_dout1 (mem_dout1),
      .o_mem_rden1 (mem_rden1),
      .o_mem_addr1 (mem_addr1),
      .o_if_pc     (if_pc),
      .o_if_instr  (if_instr),
      .o_if_valid  (if_valid),
      .o_if_err    (if_err),
      .o_if_cnt    (if_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle synchronous read port that holds its output while rden is low.
   always @(posedge clk) begin
      if (mem_rden1) mem_dout1 <= mem[mem_addr1];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Drive one cycle of inputs, check the combinational port outputs, then check the
   // registered outputs that appear after the edge against the queued expectation.
   task automatic step(input string name, input logic s_rst, input logic s_stall,
                       input logic s_br, input logic [31:0] s_tgt,
                       input logic [31:0] e_pc, input logic e_valid, input logic e_err,
                       input logic [31:0] e_cnt);
      exp_t e;
      exp_t got;
      logic [31:0] e_instr;
      @(negedge clk);
      rst       = s_rst;
      stall     = s_stall;
      br_taken  = s_br;
      br_target = s_tgt;
      e.pc = e_pc; e.valid = e_valid; e.err = e_err; e.cnt = e_cnt;
      sb_q.push_back(e);
      #1;
      check({name, ".rden"}, {31'd0, mem_rden1}, {31'd0, s_rst | s_br | ~s_stall});
      check({name, ".addr"}, {18'd0, mem_addr1}, {18'd0, e_pc[15:2]});
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      e_instr = got.valid ? mem[got.pc[15:2]] : NOP;
      check({name, ".pc"},    if_pc,              got.pc);
      check({name, ".instr"}, if_instr,           e_instr);
      check({name, ".valid"}, {31'd0, if_valid},  {31'd0, got.valid});
      check({name, ".err"},   {31'd0, if_err},    {31'd0, got.err});
      check({name, ".cnt"},   if_cnt,             got.cnt);
   endtask

   initial begin
      n_total   = 0;
      n_pass    = 0;
      rst       = 1'b1;
      stall     = 1'b0;
      br_taken  = 1'b0;
      br_target = 32'd0;
      for (int i = 0; i < 16384; i++) mem[i] = 32'hA000_0007 | (32'(i) << 4);
      mem[0]  = 32'h0050_0093;
      mem[1]  = 32'h00A0_0113;
      mem[16] = 32'h0123_4567;

      // Boot: two reset cycles, bubble, then mem[0], mem[1]
      step("rst0",   1, 0, 0, 32'h0,         32'h0,         0, 0, 0);
      step("rst1",   1, 0, 0, 32'h0,         32'h0,         0, 0, 0);
      step("boot",   0, 0, 0, 32'h0,         32'h0,         1, 0, 0);
      step("seq4",   0, 0, 0, 32'h0,         32'h4,         1, 0, 1);
      step("seq8",   0, 0, 0, 32'h0,         32'h8,         1, 0, 2);
      // Stall for three cycles at 0x8
      step("stl0",   0, 1, 0, 32'h0,         32'h8,         1, 0, 2);
      step("stl1",   0, 1, 0, 32'h0,         32'h8,         1, 0, 2);
      step("stl2",   0, 1, 0, 32'h0,         32'h8,         1, 0, 2);
      step("rel",    0, 0, 0, 32'h0,         32'hC,         1, 0, 3);
      // Redirect together with stall
      step("brstl",  0, 1, 1, 32'h40,        32'h40,        1, 0, 3);
      step("seq44",  0, 0, 0, 32'h0,         32'h44,        1, 0, 4);
      // Faults: misaligned and out of range
      step("mis42",  0, 0, 1, 32'h42,        32'h42,        0, 1, 4);
      step("mis46",  0, 0, 0, 32'h0,         32'h46,        0, 1, 4);
      step("oor",    0, 0, 1, 32'h1_0000,    32'h1_0000,    0, 1, 4);
      // Wrap from the top of the address space
      step("top",    0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 1, 4);
      step("wrap",   0, 0, 0, 32'h0,         32'h0,         1, 0, 4);
      step("wseq",   0, 0, 0, 32'h0,         32'h4,         1, 0, 5);
      // Reset beats redirect and stall
      step("rstpri", 1, 1, 1, 32'h80,        32'h0,         0, 0, 0);
      step("boot2",  0, 0, 0, 32'h0,         32'h0,         1, 0, 0);
      step("seq4b",  0, 0, 0, 32'h0,         32'h4,         1, 0, 1);
      // Last in-range word, then step out of range
      step("edge",   0, 0, 1, 32'h0000_FFFC, 32'h0000_FFFC, 1, 0, 1);
      step("edge+",  0, 0, 0, 32'h0,         32'h1_0000,    0, 1, 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
